pattern_seq_ctrl: RTL and testbench

PATTERN_SEQ_CTRL -- requirements
Module: pattern_seq_ctrl

---
 rtl/pattern_seq_ctrl_if.sv | 30 +++
 rtl/pattern_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_pattern_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_seq_ctrl_if.sv
// Command/status bundle between a sequence requester and pattern_seq_ctrl.
// The master side issues commands and flow control; the slave side runs the sequence.
interface pattern_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_limit;
  logic             cmd_down;
  logic [REP_W-1:0] cmd_reps;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             count_valid;
  logic             wrap;
  logic             done;
  logic             busy;

  modport master (
    output cmd_valid, cmd_start, cmd_limit, cmd_down, cmd_reps, pause, abort,
    input  cmd_ready, count, count_valid, wrap, done, busy
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_limit, cmd_down, cmd_reps, pause, abort,
    output cmd_ready, count, count_valid, wrap, done, busy
  );
endinterface

// File: rtl/pattern_seq_ctrl.sv
// Multi-pass up/down count sequencer: emits start..limit (modulo 2^WIDTH) once per
// pass, repeats reps+1 times, with pause/abort control and a one-cycle done pulse.
module pattern_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  pattern_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             down_q,  down_d;
  logic [REP_W-1:0] reps_q,  reps_d;
  logic [REP_W-1:0] pass_q,  pass_d;

  logic accept;
  logic emit;
  logic at_limit;

  // Emission needs RUN with neither pause nor abort; abort outranks everything.
  assign accept   = bus.cmd_valid && bus.cmd_ready;
  assign emit     = (state_q == RUN) && !bus.pause && !bus.abort;
  assign at_limit = (count_q == limit_q);

  // NOTE: every *_d gets its current value first so no path through the case leaves
  // a variable unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    start_d = start_q;
    limit_d = limit_q;
    down_d  = down_q;
    reps_d  = reps_q;
    pass_d  = pass_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          start_d = bus.cmd_start;
          limit_d = bus.cmd_limit;
          down_d  = bus.cmd_down;
          reps_d  = bus.cmd_reps;
          count_d = bus.cmd_start;
          pass_d  = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.pause) begin
          state_d = PAUSE;
        end else if (at_limit) begin
          if (pass_q < reps_q) begin
            count_d = start_q;
            pass_d  = pass_q + REP_W'(1);
          end else begin
            state_d = DONE;
          end
        end else if (down_q) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end

      PAUSE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (!bus.pause) begin
          state_d = RUN;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, matching real hardware ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      start_q <= '0;
      limit_q <= '0;
      down_q  <= 1'b0;
      reps_q  <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      start_q <= start_d;
      limit_q <= limit_d;
      down_q  <= down_d;
      reps_q  <= reps_d;
      pass_q  <= pass_d;
    end
  end

  // Gating ready with reset keeps it low during the reset window itself.
  assign bus.cmd_ready   = (state_q == IDLE) && !reset;
  assign bus.count       = count_q;
  assign bus.count_valid = emit;
  assign bus.wrap        = emit && at_limit;
  assign bus.done        = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Self-checking bench for pattern_seq_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a queue-of-expected-emissions reference model.
module tb_pattern_seq_ctrl;
  localparam int WIDTH = 8;
  localparam int REP_W = 4;

  typedef struct {
    logic [WIDTH-1:0] v;
    bit               last;
  } emit_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pattern_seq_ctrl_if #(.WIDTH(WIDTH), .REP_W(REP_W)) bus ();

  pattern_seq_ctrl #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: remaining emissions of the active sequence, in order.
  emit_t            m_q[$];
  bit               m_active = 1'b0;
  bit               m_paused = 1'b0;
  bit               m_done   = 1'b0;
  logic [WIDTH-1:0] m_count  = '0;

  int emitted[$];
  int done_seen = 0;
  int wrap_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic load_model(input logic [WIDTH-1:0] st, input logic [WIDTH-1:0] lim,
                            input logic dn, input logic [REP_W-1:0] rp);
    m_q.delete();
    for (int p = 0; p <= int'(rp); p++) begin
      logic [WIDTH-1:0] v;
      v = st;
      forever begin
        m_q.push_back('{v: v, last: (v == lim)});
        if (v == lim) break;
        v = dn ? v - 8'd1 : v + 8'd1;
      end
    end
  endtask

  // One clock cycle: drive at negedge, check settled outputs, advance the model.
  task automatic step(input logic rst, input logic cv,
                      input logic [WIDTH-1:0] st, input logic [WIDTH-1:0] lim,
                      input logic dn, input logic [REP_W-1:0] rp,
                      input logic ps, input logic ab);
    bit exp_emit;
    bit exp_wrap;
    @(negedge clk);
    reset         = rst;
    bus.cmd_valid = cv;
    bus.cmd_start = st;
    bus.cmd_limit = lim;
    bus.cmd_down  = dn;
    bus.cmd_reps  = rp;
    bus.pause     = ps;
    bus.abort     = ab;
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
      m_paused = 1'b0;
      m_done   = 1'b0;
      m_count  = '0;
    end
    #1;
    exp_emit = !rst && m_active && !m_paused && !ps && !ab;
    exp_wrap = exp_emit && (m_q.size() > 0) && m_q[0].last;
    check("cmd_ready",   32'(bus.cmd_ready),   32'(!rst && !m_active && !m_done));
    check("busy",        32'(bus.busy),        32'(m_active || m_done));
    check("done",        32'(bus.done),        32'(m_done));
    check("count_valid", 32'(bus.count_valid), 32'(exp_emit));
    check("count",       32'(bus.count),       32'(m_count));
    check("wrap",        32'(bus.wrap),        32'(exp_wrap));
    if (bus.count_valid) emitted.push_back(int'(bus.count));
    if (bus.done) done_seen++;
    if (bus.wrap) wrap_seen++;

    if (!rst) begin
      if (m_done) begin
        m_done = 1'b0;
      end else if (!m_active) begin
        if (cv) begin
          load_model(st, lim, dn, rp);
          m_count  = st;
          m_active = 1'b1;
          m_paused = 1'b0;
        end
      end else if (ab) begin
        m_active = 1'b0;
        m_paused = 1'b0;
        m_q.delete();
      end else if (m_paused) begin
        if (!ps) m_paused = 1'b0;
      end else if (ps) begin
        m_paused = 1'b1;
      end else begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end else begin
          m_count = m_q[0].v;
        end
      end
    end
  endtask

  task automatic idle(input logic ps = 1'b0, input logic ab = 1'b0);
    step(1'b0, 1'b0, 8'(($urandom)), 8'(($urandom)), 1'($urandom), 4'($urandom), ps, ab);
  endtask

  task automatic issue(input logic [WIDTH-1:0] st, input logic [WIDTH-1:0] lim,
                       input logic dn, input logic [REP_W-1:0] rp);
    step(1'b0, 1'b1, st, lim, dn, rp, 1'b0, 1'b0);
  endtask

  task automatic run_until_done(input int budget);
    int d0;
    d0 = done_seen;
    for (int i = 0; i < budget; i++) begin
      if (done_seen != d0) break;
      idle();
    end
    if (done_seen == d0) check("timeout_done", 32'd0, 32'd1);
  endtask

  task automatic check_list(input string tag, input int exp[$]);
    check({tag, "_len"}, 32'(emitted.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < emitted.size(); i++)
      check(tag, 32'(emitted[i]), 32'(exp[i]));
  endtask

  initial begin
    int exp_list[$];
    int d0, w0;
    bus.cmd_valid = 1'b0;
    bus.cmd_start = '0;
    bus.cmd_limit = '0;
    bus.cmd_down  = 1'b0;
    bus.cmd_reps  = '0;
    bus.pause     = 1'b0;
    bus.abort     = 1'b0;

    step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'd9, 8'd9, 1'b0, 4'd0, 1'b0, 1'b0);
    idle();

    // Simple up pass, pause/abort ignored while idle.
    emitted.delete(); d0 = done_seen; w0 = wrap_seen;
    idle(1'b1, 1'b1);
    issue(8'd3, 8'd6, 1'b0, 4'd0);
    run_until_done(20);
    exp_list = '{3, 4, 5, 6};
    check_list("up_pass", exp_list);
    check("up_done_cnt", 32'(done_seen - d0), 32'd1);
    check("up_wrap_cnt", 32'(wrap_seen - w0), 32'd1);
    idle();
    check("up_ready_after", 32'(bus.cmd_ready), 32'd1);

    // Down, two passes; commands offered mid-run must be ignored.
    emitted.delete(); d0 = done_seen; w0 = wrap_seen;
    issue(8'd2, 8'd0, 1'b1, 4'd1);
    step(1'b0, 1'b1, 8'd100, 8'd50, 1'b0, 4'd7, 1'b0, 1'b0);
    run_until_done(20);
    exp_list = '{2, 1, 0, 2, 1, 0};
    check_list("down_reps", exp_list);
    check("down_done_cnt", 32'(done_seen - d0), 32'd1);
    check("down_wrap_cnt", 32'(wrap_seen - w0), 32'd2);

    // Wrap through 255 -> 0.
    emitted.delete(); d0 = done_seen;
    issue(8'd254, 8'd1, 1'b0, 4'd0);
    run_until_done(20);
    exp_list = '{254, 255, 0, 1};
    check_list("modwrap", exp_list);
    check("modwrap_done_cnt", 32'(done_seen - d0), 32'd1);

    // start == limit: one emission per pass.
    emitted.delete();
    issue(8'd77, 8'd77, 1'b1, 4'd2);
    run_until_done(20);
    exp_list = '{77, 77, 77};
    check_list("single", exp_list);

    // Pause for two cycles after emitting 4.
    emitted.delete(); d0 = done_seen;
    issue(8'd3, 8'd6, 1'b0, 4'd0);
    idle();
    idle();
    repeat (2) begin
      idle(1'b1, 1'b0);
      check("pause_hold_count", 32'(bus.count), 32'd5);
      check("pause_no_valid", 32'(bus.count_valid), 32'd0);
    end
    run_until_done(20);
    exp_list = '{3, 4, 5, 6};
    check_list("pause_seq", exp_list);
    check("pause_done_cnt", 32'(done_seen - d0), 32'd1);

    // Abort after emitting 4, with pause also high to show abort wins.
    emitted.delete(); d0 = done_seen;
    issue(8'd3, 8'd6, 1'b0, 4'd0);
    idle();
    idle();
    idle(1'b1, 1'b1);
    idle();
    check("abort_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_count", 32'(bus.count), 32'd5);
    check("abort_no_done", 32'(done_seen - d0), 32'd0);
    emitted.delete();
    issue(8'd20, 8'd22, 1'b0, 4'd0);
    run_until_done(20);
    exp_list = '{20, 21, 22};
    check_list("after_abort", exp_list);

    // Reset mid-run.
    issue(8'd40, 8'd60, 1'b0, 4'd3);
    repeat (3) idle();
    step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.cmd_ready), 32'd0);
    emitted.delete();
    issue(8'd10, 8'd12, 1'b0, 4'd0);
    run_until_done(20);
    exp_list = '{10, 11, 12};
    check_list("after_reset", exp_list);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic [WIDTH-1:0] st, lim;
      logic             dn;
      int               d;
      st  = 8'($urandom);
      dn  = 1'($urandom);
      d   = $urandom_range(0, 6);
      lim = dn ? st - 8'(d) : st + 8'(d);
      if ($urandom_range(0, 15) == 0) lim = 8'($urandom);
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0, st, lim, dn,
           4'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
